// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: decoded ID bundle and redirect/freeze inputs in, then
// per-stage control outputs, stall/flush and event counters out.
// The slave modport is the pipe itself. The master modport is its driver.
interface ctrl_pipe_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [2:0]       id_alu_category;
    logic             id_branch, id_memtoReg, id_memWrite, id_memRead;
    logic             id_immediate, id_regWrite, id_jal, id_jalr;
    logic [4:0]       id_rd, id_rs1, id_rs2;
    logic             ex_redirect;
    logic             ext_stall;

    logic             ex_valid, mem_valid, wb_valid;
    logic [2:0]       ex_alu_category;
    logic             ex_branch, ex_memtoReg, ex_memWrite, ex_memRead;
    logic             ex_immediate, ex_regWrite, ex_jal, ex_jalr;
    logic             mem_memtoReg, mem_memWrite, mem_memRead, mem_regWrite, mem_jal, mem_jalr;
    logic             wb_memtoReg, wb_regWrite, wb_jal, wb_jalr;
    logic [4:0]       ex_rd, mem_rd, wb_rd;
    logic             stall;
    logic             id_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             dbg_lu_wait;   // 1 while the load-use wait state is active

    modport slave (
        input  id_valid, id_alu_category, id_branch, id_memtoReg, id_memWrite, id_memRead,
               id_immediate, id_regWrite, id_jal, id_jalr, id_rd, id_rs1, id_rs2,
               ex_redirect, ext_stall,
        output ex_valid, mem_valid, wb_valid, ex_alu_category, ex_branch, ex_memtoReg,
               ex_memWrite, ex_memRead, ex_immediate, ex_regWrite, ex_jal, ex_jalr,
               mem_memtoReg, mem_memWrite, mem_memRead, mem_regWrite, mem_jal, mem_jalr,
               wb_memtoReg, wb_regWrite, wb_jal, wb_jalr, ex_rd, mem_rd, wb_rd,
               stall, id_flush, stall_cnt, flush_cnt, dbg_lu_wait
    );

    modport master (
        output id_valid, id_alu_category, id_branch, id_memtoReg, id_memWrite, id_memRead,
               id_immediate, id_regWrite, id_jal, id_jalr, id_rd, id_rs1, id_rs2,
               ex_redirect, ext_stall,
        input  ex_valid, mem_valid, wb_valid, ex_alu_category, ex_branch, ex_memtoReg,
               ex_memWrite, ex_memRead, ex_immediate, ex_regWrite, ex_jal, ex_jalr,
               mem_memtoReg, mem_memWrite, mem_memRead, mem_regWrite, mem_jal, mem_jalr,
               wb_memtoReg, wb_regWrite, wb_jal, wb_jalr, ex_rd, mem_rd, wb_rd,
               stall, id_flush, stall_cnt, flush_cnt, dbg_lu_wait
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Carries the decoded control bundle through EX/MEM/WB. Inserts load-use
// bubbles and flushes ID on an EX redirect.
// Interface contract: there is no valid/ready handshake. ext_stall freezes
// every stage register, the FSM and the counters. While ext_stall is high a
// redirect is ignored. It is expected to be held until the freeze ends.
module ctrl_pipe #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_pipe_if.slave bus
);
    localparam int WAIT_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

    typedef enum logic {RUN = 1'b0, LU_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] alu_category;
        logic       branch, memtoReg, memWrite, memRead, immediate, regWrite, jal, jalr;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       memtoReg, memWrite, memRead, regWrite, jal, jalr;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       memtoReg, regWrite, jal, jalr;
        logic [4:0] rd;
    } wb_t;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    ex_t               ex_q, ex_nx;
    mem_t              mem_q;
    wb_t               wb_q;
    logic              hazard, lu_stall, flush;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    // Both sources are compared for every opcode. This is conservative.
    assign hazard = bus.id_valid & ex_q.valid & ex_q.memRead & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

    // Next state and stall/flush decision. A redirect always beats a hazard.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        lu_stall    = 1'b0;
        flush       = 1'b0;
        if (!bus.ext_stall) begin
            case (state)
                RUN: begin
                    if (bus.ex_redirect) begin
                        flush = 1'b1;
                    end else if (hazard) begin
                        lu_stall = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nx    = LU_WAIT;
                            wait_cnt_nx = WAIT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                LU_WAIT: begin
                    if (bus.ex_redirect) begin
                        flush       = 1'b1;
                        state_nx    = RUN;
                        wait_cnt_nx = '0;
                    end else begin
                        lu_stall = 1'b1;
                        if (wait_cnt == WAIT_W'(1)) begin
                            state_nx    = RUN;
                            wait_cnt_nx = '0;
                        end else begin
                            wait_cnt_nx = wait_cnt - WAIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end
            endcase
        end
    end

    // EX input: the ID bundle, or an all-zero bubble when ID is empty, dead or held.
    always_comb begin
        ex_nx = '0;
        if (bus.id_valid && !flush && !lu_stall) begin
            ex_nx.valid        = 1'b1;
            ex_nx.alu_category = bus.id_alu_category;
            ex_nx.branch       = bus.id_branch;
            ex_nx.memtoReg     = bus.id_memtoReg;
            ex_nx.memWrite     = bus.id_memWrite;
            ex_nx.memRead      = bus.id_memRead;
            ex_nx.immediate    = bus.id_immediate;
            ex_nx.regWrite     = bus.id_regWrite;
            ex_nx.jal          = bus.id_jal;
            ex_nx.jalr         = bus.id_jalr;
            ex_nx.rd           = bus.id_rd;
        end
    end

    // FSM state register. The next-state logic already holds under ext_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Stage registers advance together unless the downstream freeze is on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!bus.ext_stall) begin
            ex_q  <= ex_nx;
            mem_q <= '{valid: ex_q.valid, memtoReg: ex_q.memtoReg, memWrite: ex_q.memWrite,
                       memRead: ex_q.memRead, regWrite: ex_q.regWrite, jal: ex_q.jal,
                       jalr: ex_q.jalr, rd: ex_q.rd};
            wb_q  <= '{valid: mem_q.valid, memtoReg: mem_q.memtoReg, regWrite: mem_q.regWrite,
                       jal: mem_q.jal, jalr: mem_q.jalr, rd: mem_q.rd};
        end
    end

    // Saturating event counters. Both events already imply ext_stall is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1)    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall    = rst_n & (bus.ext_stall | lu_stall);
    assign bus.id_flush = rst_n & flush;

    assign bus.ex_valid        = ex_q.valid;
    assign bus.ex_alu_category = ex_q.alu_category;
    assign bus.ex_branch       = ex_q.branch;
    assign bus.ex_memtoReg     = ex_q.memtoReg;
    assign bus.ex_memWrite     = ex_q.memWrite;
    assign bus.ex_memRead      = ex_q.memRead;
    assign bus.ex_immediate    = ex_q.immediate;
    assign bus.ex_regWrite     = ex_q.regWrite;
    assign bus.ex_jal          = ex_q.jal;
    assign bus.ex_jalr         = ex_q.jalr;
    assign bus.ex_rd           = ex_q.rd;

    assign bus.mem_valid    = mem_q.valid;
    assign bus.mem_memtoReg = mem_q.memtoReg;
    assign bus.mem_memWrite = mem_q.memWrite;
    assign bus.mem_memRead  = mem_q.memRead;
    assign bus.mem_regWrite = mem_q.regWrite;
    assign bus.mem_jal      = mem_q.jal;
    assign bus.mem_jalr     = mem_q.jalr;
    assign bus.mem_rd       = mem_q.rd;

    assign bus.wb_valid    = wb_q.valid;
    assign bus.wb_memtoReg = wb_q.memtoReg;
    assign bus.wb_regWrite = wb_q.regWrite;
    assign bus.wb_jal      = wb_q.jal;
    assign bus.wb_jalr     = wb_q.jalr;
    assign bus.wb_rd       = wb_q.rd;

    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.dbg_lu_wait = (state == LU_WAIT);
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe. It drives two instances from one stimulus stream.
// d1 uses a 1-cycle load-use stall and 16-bit counters. d3 uses a 3-cycle
// stall and 2-bit counters. A cycle-level reference model predicts every
// output, and the predictions are queued for the monitor.
module tb_ctrl_pipe;
    typedef struct packed {
        logic       valid;
        logic [2:0] alu;
        logic       branch, memtoReg, memWrite, memRead, immediate, regWrite, jal, jalr;
        logic [4:0] rd;
    } bun_t;

    typedef struct packed {
        logic       id_valid;
        logic [2:0] alu;
        logic       branch, memtoReg, memWrite, memRead, immediate, regWrite, jal, jalr;
        logic [4:0] rd, rs1, rs2;
        logic       redirect, ext_stall;
    } stim_t;

    typedef struct packed {
        logic [2:0]  ctl;   // stall, id_flush, lu_wait
        logic [16:0] ex;
        logic [11:0] mem;
        logic [9:0]  wb;
        logic [31:0] cnt;   // stall_cnt, flush_cnt (zero-extended)
    } exp_t;

    typedef struct packed {
        bun_t ex, mem, wb;
        int   lu_left;      // stall cycles still owed after the current one
        int   scnt, fcnt;
    } model_t;

    logic   clk, rst_n;
    stim_t  cur;
    model_t m1, m3;
    exp_t   exp_q1[$], exp_q3[$];
    exp_t   act1, act3;
    int     n_cmp = 0, n_err = 0;

    ctrl_pipe_if #(.CNT_W(16)) if1 ();
    ctrl_pipe_if #(.CNT_W(2))  if3 ();

    ctrl_pipe #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    ctrl_pipe #(.LOAD_STALL_CYCLES(3), .CNT_W(2))  d3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign if1.id_valid = cur.id_valid;   assign if3.id_valid = cur.id_valid;
    assign if1.id_alu_category = cur.alu; assign if3.id_alu_category = cur.alu;
    assign if1.id_branch = cur.branch;    assign if3.id_branch = cur.branch;
    assign if1.id_memtoReg = cur.memtoReg; assign if3.id_memtoReg = cur.memtoReg;
    assign if1.id_memWrite = cur.memWrite; assign if3.id_memWrite = cur.memWrite;
    assign if1.id_memRead = cur.memRead;  assign if3.id_memRead = cur.memRead;
    assign if1.id_immediate = cur.immediate; assign if3.id_immediate = cur.immediate;
    assign if1.id_regWrite = cur.regWrite; assign if3.id_regWrite = cur.regWrite;
    assign if1.id_jal = cur.jal;          assign if3.id_jal = cur.jal;
    assign if1.id_jalr = cur.jalr;        assign if3.id_jalr = cur.jalr;
    assign if1.id_rd = cur.rd;            assign if3.id_rd = cur.rd;
    assign if1.id_rs1 = cur.rs1;          assign if3.id_rs1 = cur.rs1;
    assign if1.id_rs2 = cur.rs2;          assign if3.id_rs2 = cur.rs2;
    assign if1.ex_redirect = cur.redirect; assign if3.ex_redirect = cur.redirect;
    assign if1.ext_stall = cur.ext_stall; assign if3.ext_stall = cur.ext_stall;

    always_comb begin
        act1.ctl = {if1.stall, if1.id_flush, if1.dbg_lu_wait};
        act1.ex  = {if1.ex_valid, if1.ex_alu_category, if1.ex_branch, if1.ex_memtoReg,
                    if1.ex_memWrite, if1.ex_memRead, if1.ex_immediate, if1.ex_regWrite,
                    if1.ex_jal, if1.ex_jalr, if1.ex_rd};
        act1.mem = {if1.mem_valid, if1.mem_memtoReg, if1.mem_memWrite, if1.mem_memRead,
                    if1.mem_regWrite, if1.mem_jal, if1.mem_jalr, if1.mem_rd};
        act1.wb  = {if1.wb_valid, if1.wb_memtoReg, if1.wb_regWrite, if1.wb_jal, if1.wb_jalr, if1.wb_rd};
        act1.cnt = {if1.stall_cnt, if1.flush_cnt};
        act3.ctl = {if3.stall, if3.id_flush, if3.dbg_lu_wait};
        act3.ex  = {if3.ex_valid, if3.ex_alu_category, if3.ex_branch, if3.ex_memtoReg,
                    if3.ex_memWrite, if3.ex_memRead, if3.ex_immediate, if3.ex_regWrite,
                    if3.ex_jal, if3.ex_jalr, if3.ex_rd};
        act3.mem = {if3.mem_valid, if3.mem_memtoReg, if3.mem_memWrite, if3.mem_memRead,
                    if3.mem_regWrite, if3.mem_jal, if3.mem_jalr, if3.mem_rd};
        act3.wb  = {if3.wb_valid, if3.wb_memtoReg, if3.wb_regWrite, if3.wb_jal, if3.wb_jalr, if3.wb_rd};
        act3.cnt = {14'd0, if3.stall_cnt, 14'd0, if3.flush_cnt};
    end

    // Reference model. It predicts what is visible this cycle and the state after the edge.
    task automatic model_cycle(input model_t m, input stim_t s, input int n, input int cmax,
                               output exp_t e, output model_t nm);
        bit haz, fl, lu;
        nm  = m;
        fl  = 0;
        lu  = 0;
        haz = s.id_valid && m.ex.valid && m.ex.memRead && (m.ex.rd != 0) &&
              (m.ex.rd == s.rs1 || m.ex.rd == s.rs2);
        if (!s.ext_stall) begin
            if (s.redirect) begin
                fl = 1; nm.lu_left = 0;
            end else if (m.lu_left > 0) begin
                lu = 1; nm.lu_left = m.lu_left - 1;
            end else if (haz) begin
                lu = 1; nm.lu_left = n - 1;
            end
        end
        e.ctl = {s.ext_stall | lu, fl, m.lu_left > 0};
        e.ex  = {m.ex.valid, m.ex.alu, m.ex.branch, m.ex.memtoReg, m.ex.memWrite, m.ex.memRead,
                 m.ex.immediate, m.ex.regWrite, m.ex.jal, m.ex.jalr, m.ex.rd};
        e.mem = {m.mem.valid, m.mem.memtoReg, m.mem.memWrite, m.mem.memRead, m.mem.regWrite,
                 m.mem.jal, m.mem.jalr, m.mem.rd};
        e.wb  = {m.wb.valid, m.wb.memtoReg, m.wb.regWrite, m.wb.jal, m.wb.jalr, m.wb.rd};
        e.cnt = {16'(m.scnt), 16'(m.fcnt)};
        if (!s.ext_stall) begin
            nm.wb  = m.mem;
            nm.mem = m.ex;
            nm.ex  = '0;
            if (s.id_valid && !fl && !lu)
                nm.ex = {1'b1, s.alu, s.branch, s.memtoReg, s.memWrite, s.memRead,
                         s.immediate, s.regWrite, s.jal, s.jalr, s.rd};
            if (lu && m.scnt < cmax) nm.scnt = m.scnt + 1;
            if (fl && m.fcnt < cmax) nm.fcnt = m.fcnt + 1;
        end
    endtask

    // driver: applies one cycle of stimulus at the falling edge and queues the prediction
    task automatic drive(input stim_t s, input logic r);
        exp_t e;
        model_t nm;
        @(negedge clk);
        cur   = s;
        rst_n = r;
        if (!r) begin
            m1 = '0;
            m3 = '0;
        end
        model_cycle(m1, s, 1, 65535, e, nm);
        if (!r) e.ctl = '0; else m1 = nm;
        exp_q1.push_back(e);
        model_cycle(m3, s, 3, 3, e, nm);
        if (!r) e.ctl = '0; else m3 = nm;
        exp_q3.push_back(e);
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s           = stim_t'({$urandom, $urandom});
        s.id_valid  = ($urandom_range(0, 3) != 0);
        s.memRead   = $urandom_range(0, 1);
        s.rd        = 5'($urandom_range(0, 3));
        s.rs1       = 5'($urandom_range(0, 3));
        s.rs2       = 5'($urandom_range(0, 3));
        s.redirect  = ($urandom_range(0, 7) == 0);
        s.ext_stall = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    function automatic stim_t mk(bit v, bit ld, int rd, int rs1, int rs2, bit rdr, bit xs);
        stim_t s;
        s           = rnd_stim();
        s.id_valid  = v;
        s.memRead   = ld;
        s.rd        = 5'(rd);
        s.rs1       = 5'(rs1);
        s.rs2       = 5'(rs2);
        s.redirect  = rdr;
        s.ext_stall = xs;
        return s;
    endfunction

    task automatic cmp_field(input string dut, input string name, input logic [31:0] got,
                             input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s.%s got %h expected %h at %0t", dut, name, got, want, $time);
        end
    endtask

    task automatic check(input string dut, input exp_t e, input exp_t a);
        cmp_field(dut, "ctl", 32'(a.ctl), 32'(e.ctl));
        cmp_field(dut, "ex",  32'(a.ex),  32'(e.ex));
        cmp_field(dut, "mem", 32'(a.mem), 32'(e.mem));
        cmp_field(dut, "wb",  32'(a.wb),  32'(e.wb));
        cmp_field(dut, "cnt", a.cnt, e.cnt);
    endtask

    // scoreboard monitor: samples after the inputs settle and compares against the queued prediction
    always @(negedge clk) begin
        #1;
        if (exp_q1.size() > 0) check("d1", exp_q1.pop_front(), act1);
        if (exp_q3.size() > 0) check("d3", exp_q3.pop_front(), act3);
    end

    initial begin
        rst_n = 1'b0;
        cur   = '0;
        m1    = '0;
        m3    = '0;
        repeat (3) drive(rnd_stim(), 1'b0);
        drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // load x5 then a use of x5 through rs1
        drive(mk(1, 1, 5, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 9, 5, 0, 0, 0), 1'b1);
        repeat (4) drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // a load to x0 never stalls, and neither does a non-matching rs2
        drive(mk(1, 1, 0, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 8, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 1, 5, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 9, 1, 6, 0, 0), 1'b1);
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // load x7, use x7, redirect on the second stall cycle
        drive(mk(1, 1, 7, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 9, 7, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 9, 7, 0, 1, 0), 1'b1);
        repeat (4) drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // load x7, use x7 held through the full stall
        drive(mk(1, 1, 7, 0, 0, 0, 0), 1'b1);
        repeat (4) drive(mk(1, 0, 9, 0, 7, 0, 0), 1'b1);
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // a hazard and a redirect in the same cycle
        drive(mk(1, 1, 3, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 9, 3, 0, 1, 0), 1'b1);
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // freeze with a load in MEM and a redirect held
        drive(mk(1, 1, 4, 0, 0, 0, 0), 1'b1);
        drive(mk(1, 0, 2, 0, 0, 0, 0), 1'b1);
        repeat (4) drive(mk(1, 0, 10, 4, 4, 1, 1), 1'b1);
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // five flushes saturate d3's 2-bit counter, then a mid-stream reset
        repeat (5) drive(mk(1, 0, 2, 0, 0, 1, 0), 1'b1);
        drive(mk(1, 0, 2, 0, 0, 0, 0), 1'b1);
        repeat (2) drive(rnd_stim(), 1'b0);
        drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            drive(rnd_stim(), ($urandom_range(0, 299) != 0));

        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (exp_q1.size() + exp_q3.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d leftover expected 0", exp_q1.size() + exp_q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
